// File: rtl/serial_add_sched_if.sv
// Request/response bundle for serial_add_sched. The req_cin lane exists only when
// SERIAL_ADD_CIN_EN is defined.
interface serial_add_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
`ifdef SERIAL_ADD_CIN_EN
    logic [NREQ-1:0]       req_cin;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic [IDW-1:0]        rsp_id;

    modport slave (
`ifdef SERIAL_ADD_CIN_EN
        input  req_cin,
`endif
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

    modport master (
`ifdef SERIAL_ADD_CIN_EN
        output req_cin,
`endif
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );
endinterface

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial full-adder slice among NREQ requesters.
// Optional carry-in per requester when SERIAL_ADD_CIN_EN is defined.
module serial_add_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_sched_if.slave bus,
    output logic              busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   grant_id;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             grant_vld;
    logic             accept;
    logic             a_bit, b_bit;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin : arb
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_vld && !rst;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    assign a_bit = a_q[bit_idx_q];
    assign b_bit = b_q[bit_idx_q];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        bit_idx_d = bit_idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        a_d       = a_q;
        b_d       = b_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d       = bus.req_a[grant_id*WIDTH +: WIDTH];
                    b_d       = bus.req_b[grant_id*WIDTH +: WIDTH];
                    id_d      = grant_id;
                    rr_ptr_d  = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                    bit_idx_d = '0;
`ifdef SERIAL_ADD_CIN_EN
                    carry_d   = bus.req_cin[grant_id];
`else
                    carry_d   = 1'b0;
`endif
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                sum_d[bit_idx_q] = a_bit ^ b_bit ^ carry_q;
                carry_d          = maj3(a_bit, b_bit, carry_q);
                bit_idx_d        = bit_idx_q + 1'b1;
                if (bit_idx_q == BW'(WIDTH-1)) begin
                    bit_idx_d = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // Response registers stay frozen until the consumer takes them.
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            bit_idx_q <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            bit_idx_q <= bit_idx_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_id    = id_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched with a result scoreboard.
module tb_serial_add_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    typedef struct packed {
        logic [1:0]       id;
        logic             carry;
        logic [WIDTH-1:0] sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;
    int   last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) ifc ();

    serial_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        ifc.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        ifc.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Wait for a grant, check it, push the expected result, then wait for the response.
    task automatic one_op(input int exp_id, input logic exp_cin);
        int n;
        logic [WIDTH:0] e;
        exp_t x, got;
        n = 0;
        #1;
        while (ifc.req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("grant", ifc.req_ready, 64'(1) << exp_id);
        e = {1'b0, ifc.req_a[exp_id*WIDTH +: WIDTH]} + {1'b0, ifc.req_b[exp_id*WIDTH +: WIDTH]}
            + {{WIDTH{1'b0}}, exp_cin};
        x.id = 2'(exp_id);
        x.carry = e[WIDTH];
        x.sum = e[WIDTH-1:0];
        sb.push_back(x);
        last_acc = cyc;
        tick();
        chk("rdy_in_add", ifc.req_ready, 0);
        chk("busy_in_add", busy, 1);
        n = 1;
        while (!ifc.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, WIDTH + 1);
        if (ifc.rsp_valid && sb.size() > 0) begin
            x = sb.pop_front();
            got.id = ifc.rsp_id;
            got.carry = ifc.rsp_carry;
            got.sum = ifc.rsp_sum;
            chk("rsp_sum", got.sum, x.sum);
            chk("rsp_carry", got.carry, x.carry);
            chk("rsp_id", got.id, x.id);
        end
    endtask

    initial begin
        int prev;
        int ids[5];
        rst = 1'b1;
        ifc.req_valid = 4'b1111;
        ifc.req_a = '0;
        ifc.req_b = '0;
        ifc.rsp_ready = 1'b0;
`ifdef SERIAL_ADD_CIN_EN
        ifc.req_cin = '0;
`endif
        tick();
        tick();
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", ifc.req_ready, 0);
        chk("rst_rsp_carry", ifc.rsp_carry, 0);
        chk("rst_rsp_id", ifc.rsp_id, 0);
        chk("rst_rsp_sum", ifc.rsp_sum, 0);
        rst = 1'b0;
        ifc.req_valid = '0;
        #1;
        chk("idle_no_req", ifc.req_ready, 0);

        // Single request with backpressure in DONE; operands scrambled after accept.
        set_ops(0, 4, 1);
        ifc.req_valid = 4'b0001;
        #1;
        chk("single_grant_rdy", ifc.req_ready, 4'b0001);
        fork
            begin
                @(posedge clk);
                #2;
                ifc.req_valid = '0;
                set_ops(0, 9, 9);
            end
        join_none
        one_op(0, 1'b0);
        chk("single_sum_const", ifc.rsp_sum, 5);
        ifc.req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", ifc.rsp_valid, 1);
            chk("bp_sum", ifc.rsp_sum, 5);
            chk("bp_id", ifc.rsp_id, 0);
            chk("bp_rdy", ifc.req_ready, 0);
            tick();
        end
        ifc.rsp_ready = 1'b1;
        #1;
        chk("bp_valid4", ifc.rsp_valid, 1);
        tick();
        chk("hs_valid", ifc.rsp_valid, 0);
        chk("hs_busy", busy, 0);
        chk("hs_next_grant", ifc.req_ready, 4'b0010);
        ifc.req_valid = '0;

        // Overflow cases from requester 2.
        set_ops(2, 15, 1);
        ifc.req_valid = 4'b0100;
        one_op(2, 1'b0);
        chk("ovf1_sum", ifc.rsp_sum, 0);
        chk("ovf1_carry", ifc.rsp_carry, 1);
        tick();
        set_ops(2, 15, 15);
        one_op(2, 1'b0);
        chk("ovf2_sum", ifc.rsp_sum, 14);
        ifc.req_valid = '0;
        tick();

        // All requesting: round-robin order and WIDTH+2 issue spacing.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 3*i + 1, 2*i + 5);
        ifc.req_valid = 4'b1111;
        ids = '{0, 1, 2, 3, 0};
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            one_op(ids[k], 1'b0);
            if (k > 0) chk("issue_spacing", last_acc - prev, WIDTH + 2);
            prev = last_acc;
        end
        ifc.req_valid = '0;
        tick();

        // Two requesters alternate.
        do_reset();
        set_ops(0, 6, 7);
        set_ops(2, 12, 11);
        ifc.req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) one_op((k % 2) * 2, 1'b0);
        ifc.req_valid = '0;
        tick();

        // Reset during the second ADD cycle discards the operation.
        set_ops(0, 3, 3);
        ifc.req_valid = 4'b0001;
        #1;
        chk("mid_grant", ifc.req_ready, 4'b0001);
        tick();
        ifc.req_valid = '0;
        tick();
        rst = 1'b1;
        ifc.req_valid = 4'b1111;
        #1;
        chk("mid_rst_rdy", ifc.req_ready, 0);
        tick();
        chk("mid_rsp_valid", ifc.rsp_valid, 0);
        chk("mid_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("mid_rr_zero", ifc.req_ready, 4'b0001);
        ifc.req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_rsp", ifc.rsp_valid, 0);
        end
        set_ops(0, 9, 6);
        ifc.req_valid = 4'b0001;
        one_op(0, 1'b0);
        chk("post_rst_sum", ifc.rsp_sum, 15);
        ifc.req_valid = '0;
        tick();

`ifdef SERIAL_ADD_CIN_EN
        set_ops(1, 7, 8);
        ifc.req_cin = 4'b0010;
        ifc.req_valid = 4'b0010;
        one_op(1, 1'b1);
        chk("cin_sum", ifc.rsp_sum, 0);
        chk("cin_carry", ifc.rsp_carry, 1);
        ifc.req_valid = '0;
        ifc.req_cin = '0;
        tick();
`endif

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
